// File: rtl/sm_block_accumulator.sv
// Sums BLOCK_LEN sign-magnitude samples into a saturating ACC_W-bit sign-magnitude total with sticky overflow; SM_BLOCK_ACC_TWOS_OUT_EN selects a two's complement out_data.
// Latency: the block result is valid one cycle after the final accepted sample.
// Backpressure: in_ready is low while a result is held; the result stays held until out_ready; clear aborts everything.
module sm_block_accumulator #(
   parameter int N         = 4,
   parameter int ACC_W     = 8,
   parameter int BLOCK_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_ovf
);

   localparam int MAG_W = ACC_W - 1;
   localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);
   localparam logic [MAG_W-1:0] MAG_MAX  = '1;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             acc_sgn_q, acc_sgn_d;
   logic [MAG_W-1:0] acc_mag_q, acc_mag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;

   logic             in_sgn;
   logic [MAG_W-1:0] in_mag;
   logic [MAG_W:0]   mag_sum;
   logic             add_sgn;
   logic [MAG_W-1:0] add_mag;
   logic             add_sat;
   logic [ACC_W-1:0] res_enc;
   logic [ACC_W-1:0] res_ext;
   logic             accept;

   assign in_ready  = (state_q == ST_ACCUM);
   assign out_valid = (state_q == ST_HOLD);
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign accept    = in_valid & in_ready;

   // Sign-magnitude add of the running total and the incoming sample; -0 in is folded to +0.
   always_comb begin
      in_mag  = MAG_W'(in_data[N-2:0]);
      in_sgn  = in_data[N-1] & (|in_data[N-2:0]);
      mag_sum = {1'b0, acc_mag_q} + {1'b0, in_mag};
      add_sgn = acc_sgn_q;
      add_mag = acc_mag_q;
      add_sat = 1'b0;
      if (acc_sgn_q == in_sgn) begin
         if (mag_sum[MAG_W]) begin
            add_mag = MAG_MAX;
            add_sat = 1'b1;
         end else begin
            add_mag = mag_sum[MAG_W-1:0];
         end
      end else if (acc_mag_q >= in_mag) begin
         add_mag = acc_mag_q - in_mag;
      end else begin
         add_mag = in_mag - acc_mag_q;
         add_sgn = in_sgn;
      end
      if (add_mag == '0) begin
         add_sgn = 1'b0;
      end
   end

   always_comb begin
      res_ext = {1'b0, add_mag};
`ifdef SM_BLOCK_ACC_TWOS_OUT_EN
      res_enc = add_sgn ? (~res_ext + ACC_W'(1)) : res_ext;
`else
      res_enc = {add_sgn, add_mag};
`endif
   end

   always_comb begin
      state_d    = state_q;
      acc_sgn_d  = acc_sgn_q;
      acc_mag_d  = acc_mag_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      if (clear) begin
         state_d    = ST_ACCUM;
         acc_sgn_d  = 1'b0;
         acc_mag_d  = '0;
         cnt_d      = '0;
         ovf_d      = 1'b0;
         out_data_d = '0;
         out_ovf_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (accept) begin
                  acc_sgn_d = add_sgn;
                  acc_mag_d = add_mag;
                  ovf_d     = ovf_q | add_sat;
                  if (cnt_q == CNT_LAST) begin
                     state_d    = ST_HOLD;
                     cnt_d      = '0;
                     out_data_d = res_enc;
                     out_ovf_d  = ovf_q | add_sat;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               if (out_ready) begin
                  state_d    = ST_ACCUM;
                  acc_sgn_d  = 1'b0;
                  acc_mag_d  = '0;
                  cnt_d      = '0;
                  ovf_d      = 1'b0;
                  out_data_d = '0;
                  out_ovf_d  = 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ACCUM;
         acc_sgn_q  <= 1'b0;
         acc_mag_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_sgn_q  <= acc_sgn_d;
         acc_mag_q  <= acc_mag_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

endmodule

// File: tb/tb_sm_block_accumulator.sv
// Bench for sm_block_accumulator: directed scenarios plus random blocks on an 8-bit and a 5-bit accumulator.
module tb_sm_block_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
   logic [3:0] in_data_a;
   logic [7:0] out_data_a;
   logic       clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
   logic [3:0] in_data_b;
   logic [4:0] out_data_b;

   int checks = 0;
   int errors = 0;

`ifdef SM_BLOCK_ACC_TWOS_OUT_EN
   localparam logic [7:0] EXP_NEG7 = 8'hF9;
`else
   localparam logic [7:0] EXP_NEG7 = 8'h87;
`endif

   sm_block_accumulator #(.N(4), .ACC_W(8), .BLOCK_LEN(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_data(out_data_a), .out_ovf(out_ovf_a)
   );

   sm_block_accumulator #(.N(4), .ACC_W(5), .BLOCK_LEN(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_data(out_data_b), .out_ovf(out_ovf_b)
   );

   // Reference: signed integer running sum clamped to +-(2^(accw-1)-1); sample 0 is the low nibble.
   function automatic void model_block(input logic [15:0] s, input int accw,
                                       output logic [7:0] res, output logic ovf);
      int acc, v, lim;
      logic [3:0] c;
      lim = (1 << (accw - 1)) - 1;
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c = s[i*4 +: 4];
         v = int'(c[2:0]);
         if (c[3]) v = -v;
         acc = acc + v;
         if (acc > lim) begin
            acc = lim; ovf = 1'b1;
         end else if (acc < -lim) begin
            acc = -lim; ovf = 1'b1;
         end
      end
`ifdef SM_BLOCK_ACC_TWOS_OUT_EN
      res = 8'(acc & ((1 << accw) - 1));
`else
      res = (acc < 0) ? 8'((1 << (accw - 1)) | (-acc)) : 8'(acc);
`endif
   endfunction

   task automatic send_a(input logic [3:0] d);
      in_valid_a = 1'b1; in_data_a = d;
      @(posedge clk); #1;
      in_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [3:0] d);
      in_valid_b = 1'b1; in_data_b = d;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
   endtask

   task automatic block_a(input logic [15:0] s);
      for (int i = 0; i < 4; i++) send_a(s[i*4 +: 4]);
   endtask

   task automatic block_b(input logic [15:0] s);
      for (int i = 0; i < 4; i++) send_b(s[i*4 +: 4]);
   endtask

   task automatic pop_a();
      out_ready_a = 1'b1;
      @(posedge clk); #1;
      out_ready_a = 1'b0;
   endtask

   task automatic pop_b();
      out_ready_b = 1'b1;
      @(posedge clk); #1;
      out_ready_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_a); end
      checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data_a); end
      checks++; if (out_ovf_a !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf_a); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
      checks++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_b got v=%b r=%b want v=0 r=1", out_valid_b, in_ready_b); end
   endtask

   task automatic test_basic_sum();
      send_a(4'b0011); send_a(4'b0101); send_a(4'b1010);
      checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL sum_midblock got v=%b r=%b want v=0 r=1", out_valid_a, in_ready_a); end
      send_a(4'b0001);
      checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL sum_latency out_valid got %b want 1", out_valid_a); end
      checks++; if (out_data_a !== 8'h07) begin errors++; $display("FAIL sum_data got %h want 07", out_data_a); end
      checks++; if (out_ovf_a !== 1'b0 || in_ready_a !== 1'b0) begin errors++; $display("FAIL sum_ovf_ready got ovf=%b r=%b want 0 0", out_ovf_a, in_ready_a); end
      pop_a();
      checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL sum_release got v=%b r=%b want v=0 r=1", out_valid_a, in_ready_a); end
   endtask

   task automatic test_neg_zero();
      block_a({4'b0000, 4'b1000, 4'b1011, 4'b0011});
      checks++; if (out_data_a !== 8'h00 || out_ovf_a !== 1'b0) begin errors++; $display("FAIL negzero_cancel got %h ovf=%b want 00 ovf=0", out_data_a, out_ovf_a); end
      pop_a();
      block_a({4'b0000, 4'b0000, 4'b0000, 4'b1111});
      checks++; if (out_data_a !== EXP_NEG7) begin errors++; $display("FAIL negzero_neg7 got %h want %h", out_data_a, EXP_NEG7); end
      pop_a();
   endtask

   task automatic test_saturation();
      block_b({4'b1111, 4'b0111, 4'b0111, 4'b0111});
      checks++; if (out_data_b !== 5'b01000 || out_ovf_b !== 1'b1) begin errors++; $display("FAIL sat_block got %b ovf=%b want 01000 ovf=1", out_data_b, out_ovf_b); end
      pop_b();
      block_b({4'b0001, 4'b0001, 4'b0001, 4'b0001});
      checks++; if (out_data_b !== 5'b00100 || out_ovf_b !== 1'b0) begin errors++; $display("FAIL sat_next_block got %b ovf=%b want 00100 ovf=0", out_data_b, out_ovf_b); end
      pop_b();
   endtask

   task automatic test_backpressure();
      logic [15:0] s;
      logic [7:0]  exp_d;
      logic        exp_o;
      s = 16'($urandom);
      model_block(s, 8, exp_d, exp_o);
      block_a(s);
      for (int c = 0; c < 5; c++) begin
         in_valid_a = 1'b1; in_data_a = 4'b0111;
         @(posedge clk); #1;
         checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== exp_d) begin
            errors++; $display("FAIL bp_hold cyc %0d got r=%b v=%b d=%h want r=0 v=1 d=%h", c, in_ready_a, out_valid_a, out_data_a, exp_d);
         end
      end
      pop_a();
      in_valid_a = 1'b0;
      checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid_a, in_ready_a); end
      s = 16'($urandom);
      model_block(s, 8, exp_d, exp_o);
      block_a(s);
      checks++; if (out_data_a !== exp_d || out_ovf_a !== exp_o) begin errors++; $display("FAIL bp_next_block got %h ovf=%b want %h ovf=%b", out_data_a, out_ovf_a, exp_d, exp_o); end
      pop_a();
   endtask

   task automatic test_clear();
      send_a(4'b0101); send_a(4'b0101);
      clear_a = 1'b1; in_valid_a = 1'b1; in_data_a = 4'b0111;
      @(posedge clk); #1;
      clear_a = 1'b0; in_valid_a = 1'b0;
      block_a({4'b0001, 4'b0001, 4'b0001, 4'b0001});
      checks++; if (out_data_a !== 8'h04 || out_ovf_a !== 1'b0) begin errors++; $display("FAIL clear_partial got %h ovf=%b want 04 ovf=0", out_data_a, out_ovf_a); end
      clear_a = 1'b1;
      @(posedge clk); #1;
      clear_a = 1'b0;
      checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL clear_hold got v=%b r=%b want v=0 r=1", out_valid_a, in_ready_a); end
      send_b(4'b0111); send_b(4'b0111); send_b(4'b0111);
      clear_b = 1'b1;
      @(posedge clk); #1;
      clear_b = 1'b0;
      block_b({4'b0001, 4'b0001, 4'b0001, 4'b0001});
      checks++; if (out_data_b !== 5'b00100 || out_ovf_b !== 1'b0) begin errors++; $display("FAIL clear_ovf got %b ovf=%b want 00100 ovf=0", out_data_b, out_ovf_b); end
      pop_b();
   endtask

   task automatic test_async_reset();
      send_a(4'b0010); send_a(4'b0010);
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      block_a({4'b0010, 4'b0010, 4'b0010, 4'b0010});
      checks++; if (out_data_a !== 8'h08 || out_valid_a !== 1'b1) begin errors++; $display("FAIL rst_midblock got %h v=%b want 08 v=1", out_data_a, out_valid_a); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid_a !== 1'b0 || out_data_a !== 8'h00 || out_ovf_a !== 1'b0) begin
         errors++; $display("FAIL rst_async_hold got v=%b d=%h ovf=%b want 0 00 0", out_valid_a, out_data_a, out_ovf_a);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_release in_ready got %b want 1", in_ready_a); end
   endtask

   task automatic test_random();
      logic [15:0] s;
      logic [7:0]  exp_d;
      logic        exp_o;
      for (int blk = 0; blk < 25; blk++) begin
         s = 16'($urandom);
         model_block(s, 8, exp_d, exp_o);
         for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin
               in_data_a = 4'($urandom);
               @(posedge clk); #1;
            end
            send_a(s[i*4 +: 4]);
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         checks++; if (out_valid_a !== 1'b1 || out_data_a !== exp_d || out_ovf_a !== exp_o) begin
            errors++; $display("FAIL rand_a blk %0d got v=%b d=%h ovf=%b want v=1 d=%h ovf=%b", blk, out_valid_a, out_data_a, out_ovf_a, exp_d, exp_o);
         end
         pop_a();
      end
      for (int blk = 0; blk < 25; blk++) begin
         s = 16'($urandom);
         model_block(s, 5, exp_d, exp_o);
         for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) begin
               in_data_b = 4'($urandom);
               @(posedge clk); #1;
            end
            send_b(s[i*4 +: 4]);
         end
         checks++; if (out_valid_b !== 1'b1 || out_data_b !== exp_d[4:0] || out_ovf_b !== exp_o) begin
            errors++; $display("FAIL rand_b blk %0d got v=%b d=%b ovf=%b want v=1 d=%b ovf=%b", blk, out_valid_b, out_data_b, out_ovf_b, exp_d[4:0], exp_o);
         end
         pop_b();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_a = 1'b0; in_valid_a = 1'b0; in_data_a = 4'h0; out_ready_a = 1'b0;
      clear_b = 1'b0; in_valid_b = 1'b0; in_data_b = 4'h0; out_ready_b = 1'b0;
      test_reset();
      test_basic_sum();
      test_neg_zero();
      test_saturation();
      test_backpressure();
      test_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
